// File: rtl/sonic_st_timing_adapter_fifo_if.sv
// Avalon-ST beat channel (valid/data/error/ready) used on both sides of the
// timing adapter FIFO.
interface sonic_st_timing_adapter_fifo_if #(
  parameter int DATA_W = 40,
  parameter int ERR_W  = 7
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic [ERR_W-1:0]  error;
  logic              ready;

  modport master (output valid, data, error, input  ready);
  modport slave  (input  valid, data, error, output ready);
endinterface

// File: rtl/sonic_st_timing_adapter_fifo.sv
// Avalon-ST timing adapter: buffers beats in a DEPTH-entry FIFO, honours an
// upstream ready latency of IN_RL, and drops/counts beats that arrive while full.
module sonic_st_timing_adapter_fifo #(
  parameter int DATA_W = 40,
  parameter int ERR_W  = 7,
  parameter int DEPTH  = 8,
  parameter int IN_RL  = 0,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  sonic_st_timing_adapter_fifo_if.slave  in_st,
  sonic_st_timing_adapter_fifo_if.master out_st,
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic                         overflow,
  output logic [CNT_W-1:0]             overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [FW-1:0]    FULL    = FW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [ERR_W-1:0]  error;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t            mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic             in_ready_q, in_ready_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop, wr_en, drop;

  // NOTE: every signal gets a value on every path here, so no latch is inferred.
  always_comb begin
    pop        = (fill_q != '0) && out_st.ready;
    wr_en      = in_st.valid && ((fill_q != FULL) || pop);
    drop       = in_st.valid && !wr_en;
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
    fill_d     = fill_q;
    if (wr_en && !pop)      fill_d = fill_q + 1'b1;
    else if (pop && !wr_en) fill_d = fill_q - 1'b1;
    // Keep IN_RL slots free for beats already in flight when ready drops.
    in_ready_d = (DEPTH - int'(fill_d)) > IN_RL;
    overflow_d = drop;
    cnt_d      = (drop && (cnt_q != CNT_MAX)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      in_ready_q <= 1'b1;
      overflow_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      in_ready_q <= in_ready_d;
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and fill decide which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{error: in_st.error, data: in_st.data};
  end

  assign in_st.ready   = in_ready_q;
  assign out_st.valid  = (fill_q != '0);
  assign out_st.data   = mem_q[rd_ptr_q].data;
  assign out_st.error  = mem_q[rd_ptr_q].error;
  assign fill_level    = fill_q;
  assign overflow      = overflow_q;
  assign overflow_cnt  = cnt_q;

endmodule
